// File: rtl/div_unit_pkg.sv
// Shared parameters for the execute-stage divider: operation codes,
// the zero constant, the divider state type and its iteration count.
package div_unit_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OPDIV  = 5'd12;
    localparam logic [OP_W-1:0] OPDIVU = 5'd13;
    localparam logic [OP_W-1:0] OPREM  = 5'd14;
    localparam logic [OP_W-1:0] OPREMU = 5'd15;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic             iKill;
    logic [OP_W-1:0]  iControl;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oResult;

    // Execute-stage side: issues operations, consumes the result.
    modport master (
        output iStart, iKill, iControl, iA, iB,
        input  oBusy, oDone, oResult
    );

    // Divider side.
    modport slave (
        input  iStart, iKill, iControl, iA, iB,
        output oBusy, oDone, oResult
    );

endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes for WIDTH cycles, then applies the sign
// correction and the divide-by-zero override while registering oResult.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input logic       iCLK,
    input logic       iRST,
    div_unit_if.slave bus
);

    div_state_t       state;
    logic [OP_W-1:0]  op;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [5:0]       cnt;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // Two's-complement negate when n is set; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude of the most negative value.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             n);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return n ? $unsigned(-s) : v;
    endfunction

    // Sign correction plus special-case overrides applied on completion.
    function automatic logic [WIDTH-1:0] finalize(input logic [OP_W-1:0]  o,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] r,
                                                  input logic             nq,
                                                  input logic             nr,
                                                  input logic             bz);
        logic [WIDTH-1:0] res;
        case (o)
            OPDIV:   res = bz ? '1 : neg_if(q, nq);
            OPDIVU:  res = bz ? '1 : q;
            OPREM:   res = neg_if(r, nr);
            OPREMU:  res = r;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Operand sign decode and one shift/subtract step of the restoring divide.
    always_comb begin
        signed_op = (bus.iControl == OPDIV) || (bus.iControl == OPREM);
        a_neg     = signed_op && bus.iA[WIDTH-1];
        b_neg     = signed_op && bus.iB[WIDTH-1];
        rem_sh    = {rem, quo[WIDTH-1]};
        fits      = (rem_sh >= {1'b0, dvs});
        rem_nx    = rem_sh[WIDTH-1:0];
        quo_nx    = {quo[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_nx = rem_sh[WIDTH-1:0] - dvs;
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end
    end

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            op          <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            bus.oBusy   <= 1'b0;
            bus.oDone   <= 1'b0;
            bus.oResult <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.oDone <= 1'b0;
                    if (bus.iStart && !bus.iKill) begin
                        op        <= bus.iControl;
                        neg_q     <= a_neg ^ b_neg;
                        neg_r     <= a_neg;
                        b_zero    <= (bus.iB == '0);
                        quo       <= neg_if(bus.iA, a_neg);
                        dvs       <= neg_if(bus.iB, b_neg);
                        rem       <= '0;
                        cnt       <= '0;
                        bus.oBusy <= 1'b1;
                        state     <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (bus.iKill) begin
                        bus.oBusy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(WIDTH - 1)) begin
                            bus.oResult <= finalize(op, quo_nx, rem_nx, neg_q, neg_r, b_zero);
                            bus.oBusy   <= 1'b0;
                            bus.oDone   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                default: begin
                    bus.oBusy <= 1'b0;
                    bus.oDone <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops, in the execute stage beside the combinational ALU.
- Receives the same iControl code and operands the ALU receives.
- Holds the pipeline via oBusy. Returns a registered quotient or remainder that the execute-stage result mux selects instead of the ALU's oResult when oDone is high.
- Removes the combinational divide path from the critical timing path.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  reset, asynchronous, active-low; the whole block clears immediately when iRST=0.
- iStart  input  1  start request; sampled only in IDLE or DONE.
- iKill  input  1  synchronous abort (pipeline flush).
- iControl  input  5  operation code: OPDIV, OPDIVU, OPREM or OPREMU.
- iA  input  WIDTH  dividend.
- iB  input  WIDTH  divisor.
- oBusy  output  1  high while iterating; the pipeline stalls.
- oDone  output  1  single-cycle pulse; oResult is valid.
- oResult  output  WIDTH  result; held until the next completion.

Behaviour:
- States:
  - IDLE: waiting for a start.
  - CALC: iterating; a 6-bit counter counts WIDTH iterations.
  - DONE: one cycle; oDone=1 and oResult is updated.
- Reset values: state=IDLE, oBusy=0, oDone=0, oResult=ZERO, internal registers 0. Reset mid-operation abandons the operation with no oDone.
- Start (edge E, state IDLE or DONE, iStart=1, iKill=0):
  - Latch iControl, the sign flags and the operand magnitudes.
  - Signed ops: magnitude = two's-complement absolute value; 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - Unsigned ops: the raw operands.
  - Go to CALC and clear the counter.
- Per CALC edge:
  - Shift {remainder, quotient} left by 1 and subtract the divisor magnitude.
  - If the difference is non-negative, keep it and set quotient bit0=1; otherwise restore and set bit0=0.
  - The state goes to DONE on the edge that completes iteration WIDTH.
- Latency: oBusy=1 for exactly 32 cycles, from after E through E+32. oDone=1 during the cycle after edge E+32, i.e. the 33rd cycle after the start edge. The latency is fixed regardless of operands or special cases.
- Final correction, registered into oResult on the CALC→DONE edge:
  - DIV: quotient, negated if sign(A)^sign(B).
  - REM: remainder, negated if sign(A).
  - DIVU/REMU: no correction.
- Special cases (override, same latency):
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. The algorithm produces these naturally; verify them explicitly.
  - Any other iControl latched at start gives ZERO after full latency.
- DONE always returns to IDLE on the next edge, unless iStart=1, in which case it goes straight to CALC (back-to-back operations, no bubble).
- iStart while oBusy=1 is ignored. Operand changes during CALC have no effect.
- iKill=1 in CALC: go to IDLE next edge; no oDone; oResult unchanged.
- iKill=1 in DONE: oDone still completes this cycle, and iStart in the same cycle is ignored.
- iKill with iStart in IDLE: the start is ignored.
- oResult changes only on the CALC→DONE edge or on reset.

Decomposition:
- Shared parameter package (existing global parameters file):
  - OPDIV, OPDIVU, OPREM, OPREMU, ZERO.
  - A new divider-state typedef: IDLE, CALC, DONE.
  - The constant DIV_CYCLES=32.
- No sub-module. The datapath (shift/subtract step plus sign correction) lives in this module; a separate step module would add ports without reuse.

Test Plan:
- DIVU, A=100, B=7, start pulse → oBusy high 32 cycles; oDone on the 33rd cycle after the start edge with oResult=14. Repeat as REMU → 2.
- DIV A=-7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD (-3). REM, same operands → 0xFFFFFFFF (-1); REM A=7, B=-2 → 1.
- Divide by zero:
  - DIV and DIVU with A=123, B=0 → 0xFFFFFFFF.
  - REM and REMU with A=123, B=0 → 123.
  - Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. All at the same latency.
- iKill at cycle 10 of CALC → oBusy drops next cycle, no oDone, oResult keeps the previous value. A new start afterwards completes correctly.
- iRST driven low asynchronously mid-CALC (between clock edges) → oBusy, oDone and oResult are 0 immediately. After release, a DIVU 50/5 completes → 10.
- Back-to-back: iStart held high in the DONE cycle with new operands (DIVU 9/3) → no idle bubble; the second oDone arrives 33 cycles after the DONE cycle with 3. A second iStart during oBusy is ignored.
